// File: rtl/pg_loader.sv
// rtl/pg_loader.sv - byte-serial program loader feeding the core programming port
//
// Receives a framed image (A5, N lo, N hi, N words low byte first, optional
// checksum) and writes each word through pg/pg_instr while holding the core
// in reset with boot_addr steering its PC to the word's address.
//
// Optional feature macro: PGLD_CHECKSUM_EN (adds a trailing XOR checksum byte).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data/rx_valid    incoming byte stream
//   rx_ready            loader can accept a byte
//   pg_instr, pg        instruction word and one-cycle write strobe
//   boot_addr           core reset vector (instrAddr)
//   cpu_rstz            core reset, low while loading
//   busy, done, err     frame in progress / core running / frame rejected

module pg_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] pg_instr,
    output logic        pg,
    output logic [15:0] boot_addr,
    output logic        cpu_rstz,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA_LO, S_DATA_HI,
        S_CSUM, S_BOOT, S_RUN, S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  len_lo;
    logic [7:0]  lo_byte;
    logic [15:0] word_cnt;
    logic        xfer;
    logic [15:0] hdr_len;
    logic        len_bad;
    logic        last_word;
`ifdef PGLD_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = rx_valid && rx_ready;
    assign hdr_len   = {rx_data, len_lo};
    assign len_bad   = (hdr_len == 16'd0) || ({1'b0, hdr_len} > MAX_N);
    assign last_word = (word_cnt == 16'd1);

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid && rx_data == SYNC_BYTE) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = S_HDR_HI;
            end
            S_HDR_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = len_bad ? S_ERR : S_DATA_LO;
            end
            S_DATA_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = S_DATA_HI;
            end
            S_DATA_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
`ifdef PGLD_CHECKSUM_EN
                    state_nxt = last_word ? S_CSUM : S_DATA_LO;
`else
                    state_nxt = last_word ? S_BOOT : S_DATA_LO;
`endif
                end
            end
`ifdef PGLD_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = (rx_data == csum) ? S_BOOT : S_ERR;
            end
`endif
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
        if (rst) rx_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pg        <= 1'b0;
            pg_instr  <= 16'h0000;
            boot_addr <= BASE_ADDR;
            cpu_rstz  <= 1'b0;
            len_lo    <= 8'h00;
            lo_byte   <= 8'h00;
            word_cnt  <= 16'h0000;
`ifdef PGLD_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            state    <= state_nxt;
            pg       <= 1'b0;
            // Core leaves reset exactly when the loader enters RUN.
            cpu_rstz <= (state_nxt == S_RUN);
            if (xfer) begin
                case (state)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) boot_addr <= BASE_ADDR;
                    end
                    S_HDR_LO: begin
                        len_lo <= rx_data;
`ifdef PGLD_CHECKSUM_EN
                        csum   <= rx_data;
`endif
                    end
                    S_HDR_HI: begin
                        word_cnt <= hdr_len;
`ifdef PGLD_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                    end
                    S_DATA_LO: begin
                        lo_byte <= rx_data;
`ifdef PGLD_CHECKSUM_EN
                        csum    <= csum ^ rx_data;
`endif
                    end
                    S_DATA_HI: begin
                        // The core samples boot_addr one cycle late, so the
                        // pulse issued next cycle still sees this word's address.
                        pg_instr  <= {rx_data, lo_byte};
                        pg        <= 1'b1;
                        word_cnt  <= word_cnt - 16'd1;
                        boot_addr <= last_word ? BASE_ADDR : boot_addr + 16'd2;
`ifdef PGLD_CHECKSUM_EN
                        csum      <= csum ^ rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                  (state == S_DATA_LO) || (state == S_DATA_HI) ||
                  (state == S_CSUM) || (state == S_BOOT);
    assign done = (state == S_RUN);
    assign err  = (state == S_ERR);

endmodule
